// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: req/ack handshake with a variable-latency RAM,
// store lane steering, load extraction/extension, and pipeline stall generation.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memAluOut,
  input  logic [31:0] memWriteToMemData,
  input  logic        memMemRead,
  input  logic        memMemWrite,
  input  logic [2:0]  memMemMode,
  output logic        dmemReq,
  output logic        dmemWe,
  output logic [31:0] dmemAddr,
  output logic [3:0]  dmemByteEn,
  output logic [31:0] dmemWData,
  input  logic [31:0] dmemRData,
  input  logic        dmemAck,
  output logic        memStall,
  output logic [31:0] memReadData,
  output logic        memAddrErr
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  mode_q, mode_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rdata_q, rdata_d;

  logic        access, is_byte, is_half, misal;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_val;

  always_comb begin
    access  = memMemRead | memMemWrite;
    is_byte = (memMemMode == 3'b001) | (memMemMode == 3'b010);
    is_half = (memMemMode == 3'b011) | (memMemMode == 3'b100);
    misal   = is_half ? memAluOut[0]
                      : (!is_byte && (memAluOut[1:0] != 2'b00));
    st_be   = 4'b1111;
    st_data = memWriteToMemData;
    if (is_byte) begin
      st_be   = 4'b0001 << memAluOut[1:0];
      st_data = {4{memWriteToMemData[7:0]}};
    end else if (is_half) begin
      st_be   = memAluOut[1] ? 4'b1100 : 4'b0011;
      st_data = {2{memWriteToMemData[15:0]}};
    end
  end

  // Load path works from the offset/mode captured at request time.
  always_comb begin
    ld_b = dmemRData[7:0];
    unique case (off_q)
      2'd0: ld_b = dmemRData[7:0];
      2'd1: ld_b = dmemRData[15:8];
      2'd2: ld_b = dmemRData[23:16];
      2'd3: ld_b = dmemRData[31:24];
    endcase
    ld_h = off_q[1] ? dmemRData[31:16] : dmemRData[15:0];
    unique case (mode_q)
      3'b001:  ld_val = {{24{ld_b[7]}}, ld_b};
      3'b010:  ld_val = {24'h0, ld_b};
      3'b011:  ld_val = {{16{ld_h[15]}}, ld_h};
      3'b100:  ld_val = {16'h0, ld_h};
      default: ld_val = dmemRData;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    mode_d  = mode_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (access && !misal) begin
          state_d = REQ;
          req_d   = 1'b1;
          we_d    = memMemWrite;
          addr_d  = {memAluOut[31:2], 2'b00};
          be_d    = memMemWrite ? st_be : 4'b0000;
          wdata_d = memMemWrite ? st_data : 32'h0;
          mode_d  = memMemMode;
          off_d   = memAluOut[1:0];
        end
      end
      REQ: begin
        if (dmemAck) begin
          state_d = DONE;
          if (!we_q) rdata_d = ld_val;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = 32'h0;
          be_d    = 4'b0000;
          wdata_d = 32'h0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
      mode_q  <= 3'b000;
      off_q   <= 2'b00;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      mode_q  <= mode_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
    end
  end

  assign dmemReq     = req_q;
  assign dmemWe      = we_q;
  assign dmemAddr    = addr_q;
  assign dmemByteEn  = be_q;
  assign dmemWData   = wdata_q;
  assign memReadData = rdata_q;
  assign memAddrErr  = (state_q == IDLE) & access & misal;
  assign memStall    = ((state_q == IDLE) & access & !misal) | (state_q == REQ);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small wait-state RAM responder.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] memAluOut, memWriteToMemData;
  logic        memMemRead, memMemWrite;
  logic [2:0]  memMemMode;
  logic        dmemReq, dmemWe;
  logic [31:0] dmemAddr, dmemWData;
  logic [3:0]  dmemByteEn;
  logic [31:0] dmemRData;
  logic        dmemAck;
  logic        memStall, memAddrErr;
  logic [31:0] memReadData;

  int nvec = 0;
  int nfail = 0;
  int req_count = 0;

  logic [31:0] mem [0:255];
  int          wait_n = 0;
  int          cnt = 0;
  bit          ram_en = 1'b1;
  logic        man_ack = 1'b0;
  logic [31:0] man_rdata = 32'h0;

  mem_access_unit dut (
    .clk(clk), .reset(reset),
    .memAluOut(memAluOut), .memWriteToMemData(memWriteToMemData),
    .memMemRead(memMemRead), .memMemWrite(memMemWrite),
    .memMemMode(memMemMode),
    .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr),
    .dmemByteEn(dmemByteEn), .dmemWData(dmemWData),
    .dmemRData(dmemRData), .dmemAck(dmemAck),
    .memStall(memStall), .memReadData(memReadData),
    .memAddrErr(memAddrErr)
  );

  always #5 clk = ~clk;

  always @(posedge dmemReq) req_count++;

  // RAM: acks after wait_n full REQ cycles, writes honour byte enables
  always @(negedge clk) begin
    logic        a;
    logic [31:0] r;
    a = 1'b0;
    r = 32'h0;
    if (ram_en) begin
      if (dmemReq && !reset) begin
        if (cnt == wait_n) begin
          a   = 1'b1;
          cnt = 0;
          if (dmemWe) begin
            for (int k = 0; k < 4; k++)
              if (dmemByteEn[k])
                mem[dmemAddr[9:2]][k*8 +: 8] = dmemWData[k*8 +: 8];
          end else begin
            r = mem[dmemAddr[9:2]];
          end
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
      dmemAck   = a;
      dmemRData = r;
    end else begin
      cnt       = 0;
      dmemAck   = man_ack;
      dmemRData = man_rdata;
    end
  end

  task automatic idle_in();
    memMemRead        = 1'b0;
    memMemWrite       = 1'b0;
    memAluOut         = 32'h0;
    memWriteToMemData = 32'h0;
    memMemMode        = 3'b000;
  endtask

  // Runs one access; returns in its DONE cycle (negedge+1).
  task automatic access(input logic rd, input logic wr,
                        input logic [2:0] mode,
                        input logic [31:0] addr, input logic [31:0] data,
                        input bit b2b, output int stall,
                        output logic [31:0] a, output logic [3:0] be,
                        output logic [31:0] wd, output logic we,
                        output bit bad);
    bit first;
    memMemRead        = rd;
    memMemWrite       = wr;
    memMemMode        = mode;
    memAluOut         = addr;
    memWriteToMemData = data;
    if (b2b) @(negedge clk);
    #1;
    stall = 0; first = 1'b1; bad = 1'b0;
    a = 32'h0; be = 4'h0; wd = 32'h0; we = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (!memStall) break;
      stall++;
      if (dmemReq) begin
        if (memAddrErr) bad = 1'b1;
        if (first) begin
          a = dmemAddr; be = dmemByteEn; wd = dmemWData; we = dmemWe;
          first = 1'b0;
          memAluOut         = ~addr;
          memWriteToMemData = ~data;
          memMemMode        = 3'd7;
        end else if (dmemAddr !== a || dmemByteEn !== be ||
                     dmemWData !== wd || dmemWe !== we) begin
          bad = 1'b1;
        end
      end
      @(negedge clk); #1;
    end
    if (memStall || dmemReq || memAddrErr || first) bad = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_in();
    repeat (2) @(negedge clk);
    #1;
    nvec++;
    if ({dmemReq, dmemWe, dmemByteEn} !== 6'b0) begin
      nfail++;
      $display("FAIL rst_ctrl: got %b want 0", {dmemReq, dmemWe, dmemByteEn});
    end
    nvec++;
    if (dmemAddr !== 32'h0 || dmemWData !== 32'h0) begin
      nfail++;
      $display("FAIL rst_bus: addr %h wdata %h want 0", dmemAddr, dmemWData);
    end
    nvec++;
    if (memReadData !== 32'h0 || memStall !== 1'b0 || memAddrErr !== 1'b0) begin
      nfail++;
      $display("FAIL rst_mem: rd %h stall %b err %b want 0",
               memReadData, memStall, memAddrErr);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_load_signed_byte();
    int st; logic [31:0] a, wd; logic [3:0] be; logic we; bit bad;
    mem[8'h00] = 32'h80FF_1234;
    wait_n = 2;
    @(negedge clk);
    access(1'b1, 1'b0, 3'b001, 32'h1003, 32'h0, 1'b0, st, a, be, wd, we, bad);
    idle_in();
    nvec++;
    if (a !== 32'h1000 || be !== 4'b0000 || we !== 1'b0) begin
      nfail++;
      $display("FAIL lbs_req: addr %h be %b we %b want 00001000 0000 0", a, be, we);
    end
    nvec++;
    if (st !== 4) begin
      nfail++;
      $display("FAIL lbs_stall: got %0d want 4", st);
    end
    nvec++;
    if (bad) begin
      nfail++;
      $display("FAIL lbs_hs: got unstable/err 1 want 0");
    end
    nvec++;
    if (memReadData !== 32'hFFFF_FF80) begin
      nfail++;
      $display("FAIL lbs_data: got %h want ffffff80", memReadData);
    end
  endtask

  task automatic test_load_unsigned_half();
    int st; logic [31:0] a, wd; logic [3:0] be; logic we; bit bad;
    mem[8'h00] = 32'hBEEF_0001;
    wait_n = 0;
    @(negedge clk);
    access(1'b1, 1'b0, 3'b100, 32'h2002, 32'h0, 1'b0, st, a, be, wd, we, bad);
    idle_in();
    nvec++;
    if (st !== 2 || bad) begin
      nfail++;
      $display("FAIL lhu_stall: got %0d bad %b want 2 0", st, bad);
    end
    nvec++;
    if (a !== 32'h2000) begin
      nfail++;
      $display("FAIL lhu_addr: got %h want 00002000", a);
    end
    nvec++;
    if (memReadData !== 32'h0000_BEEF) begin
      nfail++;
      $display("FAIL lhu_data: got %h want 0000beef", memReadData);
    end
  endtask

  task automatic test_store_byte();
    int st; logic [31:0] a, wd; logic [3:0] be; logic we; bit bad;
    mem[8'h00] = 32'h0;
    wait_n = 0;
    @(negedge clk);
    access(1'b0, 1'b1, 3'b010, 32'h3001, 32'h0000_00A5, 1'b0,
           st, a, be, wd, we, bad);
    idle_in();
    nvec++;
    if (we !== 1'b1 || be !== 4'b0010 || wd !== 32'hA5A5_A5A5 || a !== 32'h3000) begin
      nfail++;
      $display("FAIL sb_req: we %b be %b wd %h addr %h want 1 0010 a5a5a5a5 00003000",
               we, be, wd, a);
    end
    nvec++;
    if (st !== 2 || bad) begin
      nfail++;
      $display("FAIL sb_stall: got %0d bad %b want 2 0", st, bad);
    end
    nvec++;
    if (memReadData !== 32'h0000_BEEF) begin
      nfail++;
      $display("FAIL sb_hold: got %h want 0000beef", memReadData);
    end
    nvec++;
    if (mem[8'h00] !== 32'h0000_A500) begin
      nfail++;
      $display("FAIL sb_ram: got %h want 0000a500", mem[8'h00]);
    end
  endtask

  task automatic test_misaligned();
    int rc; bit req_seen;
    rc = req_count;
    req_seen = 1'b0;
    @(negedge clk);
    memMemRead = 1'b1; memMemMode = 3'b000; memAluOut = 32'h4002;
    #1;
    nvec++;
    if (memAddrErr !== 1'b1 || memStall !== 1'b0) begin
      nfail++;
      $display("FAIL lw_mis: err %b stall %b want 1 0", memAddrErr, memStall);
    end
    repeat (3) begin
      @(negedge clk); #1;
      if (dmemReq !== 1'b0) req_seen = 1'b1;
    end
    nvec++;
    if (req_seen || req_count != rc || memAddrErr !== 1'b1 || memStall !== 1'b0) begin
      nfail++;
      $display("FAIL lw_mis_hold: req %b reqs %0d err %b stall %b want 0 %0d 1 0",
               req_seen, req_count, memAddrErr, memStall, rc);
    end
    memMemMode = 3'b011; memAluOut = 32'h4001;
    #1;
    nvec++;
    if (memAddrErr !== 1'b1 || memStall !== 1'b0) begin
      nfail++;
      $display("FAIL lh_mis: err %b stall %b want 1 0", memAddrErr, memStall);
    end
    memMemMode = 3'b100; memAluOut = 32'h4002;
    #1;
    nvec++;
    if (memAddrErr !== 1'b0 || memStall !== 1'b1) begin
      nfail++;
      $display("FAIL lhu_al: err %b stall %b want 0 1", memAddrErr, memStall);
    end
    idle_in();
    #1;
    nvec++;
    if (memAddrErr !== 1'b0 || memStall !== 1'b0) begin
      nfail++;
      $display("FAIL idle_out: err %b stall %b want 0 0", memAddrErr, memStall);
    end
  endtask

  task automatic test_reset_mid();
    int rc;
    ram_en = 1'b0;
    @(negedge clk);
    memMemRead = 1'b1; memMemMode = 3'b000; memAluOut = 32'h5000;
    repeat (2) @(negedge clk);
    #1;
    nvec++;
    if (dmemReq !== 1'b1) begin
      nfail++;
      $display("FAIL mid_req: got %b want 1", dmemReq);
    end
    #2 reset = 1'b1;
    #1;
    nvec++;
    if (dmemReq !== 1'b0 || memReadData !== 32'h0) begin
      nfail++;
      $display("FAIL mid_rst: req %b rd %h want 0 00000000", dmemReq, memReadData);
    end
    idle_in();
    @(negedge clk);
    reset = 1'b0;
    rc = req_count;
    man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    #1;
    man_ack = 1'b0; man_rdata = 32'h0;
    nvec++;
    if (memReadData !== 32'h0 || dmemReq !== 1'b0 || req_count != rc || memStall !== 1'b0) begin
      nfail++;
      $display("FAIL stray_ack: rd %h req %b reqs %0d stall %b want 0 0 %0d 0",
               memReadData, dmemReq, req_count, memStall, rc);
    end
    @(negedge clk);
    ram_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    int st1, st2, rc; logic [31:0] a1, a2, wd1, wd2; logic [3:0] be1, be2;
    logic we1, we2; bit bad1, bad2;
    mem[8'h04] = 32'h0;
    wait_n = 1;
    rc = req_count;
    @(negedge clk);
    access(1'b0, 1'b1, 3'b000, 32'h10, 32'h1234_5678, 1'b0,
           st1, a1, be1, wd1, we1, bad1);
    access(1'b1, 1'b0, 3'b000, 32'h10, 32'h0, 1'b1,
           st2, a2, be2, wd2, we2, bad2);
    idle_in();
    repeat (3) @(negedge clk);
    #1;
    nvec++;
    if (we1 !== 1'b1 || be1 !== 4'b1111 || wd1 !== 32'h1234_5678 || a1 !== 32'h10) begin
      nfail++;
      $display("FAIL sw_req: we %b be %b wd %h addr %h want 1 1111 12345678 00000010",
               we1, be1, wd1, a1);
    end
    nvec++;
    if (st1 !== 3 || st2 !== 3 || bad1 || bad2) begin
      nfail++;
      $display("FAIL b2b_stall: %0d %0d bad %b%b want 3 3 00", st1, st2, bad1, bad2);
    end
    nvec++;
    if (we2 !== 1'b0 || a2 !== 32'h10 || be2 !== 4'b0000) begin
      nfail++;
      $display("FAIL lw_req: we %b addr %h be %b want 0 00000010 0000", we2, a2, be2);
    end
    nvec++;
    if (memReadData !== 32'h1234_5678) begin
      nfail++;
      $display("FAIL lw_data: got %h want 12345678", memReadData);
    end
    nvec++;
    if (req_count != rc + 2) begin
      nfail++;
      $display("FAIL b2b_reqs: got %0d want %0d", req_count - rc, 2);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    dmemAck = 1'b0;
    dmemRData = 32'h0;
    test_reset();
    test_load_signed_byte();
    test_load_unsigned_half();
    test_store_byte();
    test_misaligned();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
